selector_demux: RTL and testbench

- Streaming 1-to-2 demultiplexer. It routes each input word to output channel 0 or 1 according to a per-word select bit.
- It is the inverse of the 2:1 SELECTOR mux: one source fans out to two sinks. The mux merges two sources into one.
- Each output has its own small FIFO, so a stalled sink only back-pressures words routed to that sink.
- It sits between a single producer and two independent consumers, with valid/ready handshakes on all sides.

---
 rtl/selector_demux.sv | 139 +++++++++++++
 tb/tb_selector_demux.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/selector_demux.sv
// selector_demux: streaming 1-to-2 demultiplexer; each word goes to OUT0 or OUT1 according to IN_SEL.
// Latency: a word pushed into an empty channel FIFO is presented the cycle after the push edge.
// Backpressure: IN_READY depends only on IN_SEL and the registered count of the selected FIFO (never on OUTn_READY).
// Optional build macro SELECTOR_DEMUX_CNT_EN adds 16-bit per-channel push counters OUT0_CNT / OUT1_CNT.

// Per-channel FIFO: registered head/valid, pointers wrap naturally (DEPTH must be a power of 2, >= 2).
module selector_demux_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_rdy_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             pop;

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == FULL_CNT);
  assign pop     = valid_o & pop_rdy_i;

  // Next-state pointers and occupancy; push+pop together leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State and storage registers; reset clears storage so the head reads 0 during reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end
endmodule

module selector_demux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_SEL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT0_DATA,
  output logic             OUT0_VALID,
  input  logic             OUT0_READY,
  output logic [WIDTH-1:0] OUT1_DATA,
  output logic             OUT1_VALID,
  input  logic             OUT1_READY
`ifdef SELECTOR_DEMUX_CNT_EN
  ,
  output logic [15:0]      OUT0_CNT,
  output logic [15:0]      OUT1_CNT
`endif
);
  logic full0, full1;
  logic room;
  logic push0, push1;

  // A full FIFO stalls words aimed at it even if its sink pops this cycle,
  // which keeps OUTn_READY out of the IN_READY path.
  assign room = IN_SEL ? ~full1 : ~full0;

  // RST_N only masks the visible ready; while it is low the FIFOs are held
  // in reset anyway, so the push strobes do not need it.
  assign IN_READY = RST_N & room;
  assign push0    = IN_VALID & room & ~IN_SEL;
  assign push1    = IN_VALID & room &  IN_SEL;

  selector_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .push_i      (push0),
    .push_data_i (IN_DATA),
    .pop_rdy_i   (OUT0_READY),
    .data_o      (OUT0_DATA),
    .valid_o     (OUT0_VALID),
    .full_o      (full0)
  );

  selector_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .push_i      (push1),
    .push_data_i (IN_DATA),
    .pop_rdy_i   (OUT1_READY),
    .data_o      (OUT1_DATA),
    .valid_o     (OUT1_VALID),
    .full_o      (full1)
  );

`ifdef SELECTOR_DEMUX_CNT_EN
  logic [15:0] cnt0_q, cnt1_q;

  // Free-running push counters per channel; wrap from 65535 to 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (push0) cnt0_q <= cnt0_q + 16'd1;
      if (push1) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign OUT0_CNT = cnt0_q;
  assign OUT1_CNT = cnt1_q;
`endif
endmodule

// File: tb/tb_selector_demux.sv
// Bench for selector_demux: directed steps plus random traffic against a queue-based reference.
// Each cycle the outputs are compared with the reference queues sampled 1 time unit after the falling edge.
// Inputs are driven at the falling edge; the reference advances as the rising edge would.
module tb_selector_demux;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b1;
  logic [WIDTH-1:0] IN_DATA = '0;
  logic             IN_SEL = 1'b0;
  logic             IN_VALID = 1'b0;
  logic             IN_READY;
  logic [WIDTH-1:0] OUT0_DATA;
  logic             OUT0_VALID;
  logic             OUT0_READY = 1'b0;
  logic [WIDTH-1:0] OUT1_DATA;
  logic             OUT1_VALID;
  logic             OUT1_READY = 1'b0;
`ifdef SELECTOR_DEMUX_CNT_EN
  logic [15:0]      OUT0_CNT;
  logic [15:0]      OUT1_CNT;
`endif

  selector_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IN_DATA    (IN_DATA),
    .IN_SEL     (IN_SEL),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .OUT0_DATA  (OUT0_DATA),
    .OUT0_VALID (OUT0_VALID),
    .OUT0_READY (OUT0_READY),
    .OUT1_DATA  (OUT1_DATA),
    .OUT1_VALID (OUT1_VALID),
    .OUT1_READY (OUT1_READY)
`ifdef SELECTOR_DEMUX_CNT_EN
    ,
    .OUT0_CNT   (OUT0_CNT),
    .OUT1_CNT   (OUT1_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference state: one queue per channel, plus logs of what the DUT delivered.
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [7:0]  log0[$];
  logic [7:0]  log1[$];
  logic [15:0] cnt0_m = '0;
  logic [15:0] cnt1_m = '0;
  logic        tog = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare against the reference, then advance the reference.
  task automatic cyc(input logic v, input logic s, input logic [7:0] d,
                     input logic r0, input logic r1, output logic acc);
    logic exp_rdy;
    logic p0, p1;
    @(negedge CLK);
    IN_VALID = v; IN_SEL = s; IN_DATA = d; OUT0_READY = r0; OUT1_READY = r1;
    #1;
    exp_rdy = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    chk("in_ready", IN_READY, exp_rdy);
    chk("out0_valid", OUT0_VALID, q0.size() != 0);
    chk("out1_valid", OUT1_VALID, q1.size() != 0);
    if (q0.size() != 0) chk("out0_data", OUT0_DATA, q0[0]);
    if (q1.size() != 0) chk("out1_data", OUT1_DATA, q1[0]);
`ifdef SELECTOR_DEMUX_CNT_EN
    chk("out0_cnt", OUT0_CNT, cnt0_m);
    chk("out1_cnt", OUT1_CNT, cnt1_m);
`endif
    acc = v && exp_rdy;
    p0 = (q0.size() != 0) && r0;
    p1 = (q1.size() != 0) && r1;
    if (OUT0_VALID && r0) log0.push_back(OUT0_DATA);
    if (OUT1_VALID && r1) log1.push_back(OUT1_DATA);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (s) begin q1.push_back(d); cnt1_m = cnt1_m + 16'd1; end
      else   begin q0.push_back(d); cnt0_m = cnt0_m + 16'd1; end
    end
  endtask

  // Offer one word until accepted (bounded); optionally toggle OUT0_READY each cycle.
  task automatic push_retry(input logic s, input logic [7:0] d, input logic r0,
                            input logic r1, input logic tog0);
    logic acc;
    logic rr0;
    acc = 1'b0;
    for (int n = 0; n < 16 && !acc; n++) begin
      rr0 = tog0 ? tog : r0;
      if (tog0) tog = ~tog;
      cyc(1'b1, s, d, rr0, r1, acc);
    end
    chk("push_accepted", acc, 1);
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
      n++;
    end
    chk("drain_bound", n < 20, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    IN_VALID = 1'b0; IN_SEL = 1'b1; RST_N = 1'b0;
    #1;
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out0_valid", OUT0_VALID, 0);
    chk("rst_out1_valid", OUT1_VALID, 0);
    chk("rst_out0_data", OUT0_DATA, 0);
    chk("rst_out1_data", OUT1_DATA, 0);
`ifdef SELECTOR_DEMUX_CNT_EN
    chk("rst_out0_cnt", OUT0_CNT, 0);
    chk("rst_out1_cnt", OUT1_CNT, 0);
`endif
    q0.delete(); q1.delete(); log0.delete(); log1.delete();
    cnt0_m = '0; cnt1_m = '0;
    OUT0_READY = 1'b1; OUT1_READY = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_hold_in_ready", IN_READY, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("rst_release_in_ready", IN_READY, 1);
  endtask

  initial begin
    logic acc;

    // Power-on reset.
    do_reset();

    // Alternating select, both sinks ready.
    log0.delete(); log1.delete();
    push_retry(1'b0, 8'h40, 1'b1, 1'b1, 1'b0);
    push_retry(1'b1, 8'h05, 1'b1, 1'b1, 1'b0);
    push_retry(1'b0, 8'h41, 1'b1, 1'b1, 1'b0);
    push_retry(1'b1, 8'h06, 1'b1, 1'b1, 1'b0);
    drain();
    chk("alt_log0_size", log0.size(), 2);
    chk("alt_log1_size", log1.size(), 2);
    if (log0.size() == 2) begin chk("alt_o0_0", log0[0], 8'h40); chk("alt_o0_1", log0[1], 8'h41); end
    if (log1.size() == 2) begin chk("alt_o1_0", log1[0], 8'h05); chk("alt_o1_1", log1[1], 8'h06); end

    // Back-pressure on sink 0; channel 1 keeps flowing.
    log0.delete(); log1.delete();
    cyc(1'b1, 1'b0, 8'h10, 1'b0, 1'b1, acc);
    cyc(1'b1, 1'b0, 8'h11, 1'b0, 1'b1, acc);
    cyc(1'b1, 1'b0, 8'h12, 1'b0, 1'b1, acc);
    chk("bp_third_stalled", IN_READY, 0);
    cyc(1'b1, 1'b1, 8'h20, 1'b0, 1'b1, acc);
    chk("bp_sel1_accepted", IN_READY, 1);
    push_retry(1'b0, 8'h12, 1'b1, 1'b1, 1'b0);
    drain();
    chk("bp_log0_size", log0.size(), 3);
    if (log0.size() == 3) begin
      chk("bp_o0_0", log0[0], 8'h10); chk("bp_o0_1", log0[1], 8'h11); chk("bp_o0_2", log0[2], 8'h12);
    end
    chk("bp_log1_size", log1.size(), 1);
    if (log1.size() == 1) chk("bp_o1_0", log1[0], 8'h20);

    // FIFO1 full while its sink pops: stalled this cycle, accepted the next.
    log1.delete();
    cyc(1'b1, 1'b1, 8'h30, 1'b1, 1'b0, acc);
    cyc(1'b1, 1'b1, 8'h31, 1'b1, 1'b0, acc);
    cyc(1'b1, 1'b1, 8'h32, 1'b1, 1'b1, acc);
    chk("full_pop_stalled", IN_READY, 0);
    cyc(1'b1, 1'b1, 8'h32, 1'b1, 1'b1, acc);
    chk("full_pop_next_accepted", IN_READY, 1);
    drain();
    chk("full_log1_size", log1.size(), 3);
    if (log1.size() == 3) begin
      chk("full_o1_0", log1[0], 8'h30); chk("full_o1_1", log1[1], 8'h31); chk("full_o1_2", log1[2], 8'h32);
    end

    // Pointer wrap: 0..31 into channel 0 with OUT0_READY toggling every cycle.
    log0.delete();
    for (int i = 0; i < 32; i++) push_retry(1'b0, 8'(i), 1'b0, 1'b1, 1'b1);
    drain();
    chk("wrap_log0_size", log0.size(), 32);
    if (log0.size() == 32) for (int i = 0; i < 32; i++) chk("wrap_order", log0[i], i);

    // Reset mid-operation with both FIFOs holding data.
    cyc(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, acc);
    cyc(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0, acc);
    cyc(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0, acc);
    cyc(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0, acc);
    do_reset();
    drain();

    // Random traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
    end
    drain();

`ifdef SELECTOR_DEMUX_CNT_EN
    // Push counters, including the 65535 -> 0 wrap.
    do_reset();
    for (int i = 0; i < 32; i++) push_retry(1'b0, 8'(i), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)  push_retry(1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
    drain();
    chk("cnt0_32", OUT0_CNT, 32);
    chk("cnt1_5", OUT1_CNT, 5);
    for (int i = 0; i < 65535 - 32; i++) push_retry(1'b0, 8'(i), 1'b1, 1'b1, 1'b0);
    drain();
    chk("cnt0_max", OUT0_CNT, 16'hFFFF);
    push_retry(1'b0, 8'h55, 1'b1, 1'b1, 1'b0);
    drain();
    chk("cnt0_wrap", OUT0_CNT, 0);
    chk("cnt1_hold", OUT1_CNT, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
